// File: rtl/seq_div_16by8_if.sv
// Handshake bundle for seq_div_16by8: operand request side and result response side.
// The divider takes the slave modport; the producer/consumer takes master.
interface seq_div_16by8_if #(parameter int N = 8);
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;
  logic           dz;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, dz
  );
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, dz
  );
endinterface

// File: rtl/seq_div_16by8.sv
// Restoring 2N/N divider, one quotient bit per cycle, valid/ready on both sides.
// Optional macro DIV_ZERO_SHORTCUT_EN: a zero divisor skips the iterations.
module seq_div_16by8 #(
  parameter int N = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_div_16by8_if.slave bus
);
  localparam int CW = $clog2(2*N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [2*N-1:0] d_r, q_r;
  logic [N-1:0]   v_r, r_r;
  logic [CW-1:0]  cnt_r;
  logic           dz_r;
  logic           in_rdy, out_vld;

  // The partial remainder's extra bit only exists transiently in r_sh;
  // after each restore step it is always zero, so r_r stores N bits.
  logic [N:0]     r_sh;
  logic [N-1:0]   r_sub;
  logic           q_bit, last_iter, skip;

  assign r_sh      = {r_r, d_r[2*N-1]};
  assign q_bit     = (r_sh >= {1'b0, v_r});
  assign r_sub     = r_sh[N-1:0] - v_r;
  assign last_iter = (cnt_r == CW'(2*N-1));

`ifdef DIV_ZERO_SHORTCUT_EN
  assign skip = dz_r;
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    out_vld   = 1'b0;
    case (state)
      IDLE: begin
        in_rdy = 1'b1;
        if (bus.in_valid) state_nxt = RUN;
      end
      RUN:  if (skip || last_iter) state_nxt = DONE;
      DONE: begin
        out_vld = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_r   <= '0;
      v_r   <= '0;
      r_r   <= '0;
      q_r   <= '0;
      cnt_r <= '0;
      dz_r  <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      d_r   <= bus.dividend;
      v_r   <= bus.divisor;
      r_r   <= '0;
      q_r   <= '0;
      cnt_r <= '0;
      dz_r  <= (bus.divisor == '0);
    end else if (state == RUN) begin
      if (skip) begin
        // D has not shifted yet, so its low half is still the dividend's.
        q_r <= '1;
        r_r <= d_r[N-1:0];
      end else begin
        d_r   <= {d_r[2*N-2:0], 1'b0};
        r_r   <= q_bit ? r_sub : r_sh[N-1:0];
        q_r   <= {q_r[2*N-2:0], q_bit};
        cnt_r <= cnt_r + 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.quotient  = q_r;
  assign bus.remainder = r_r;
  assign bus.dz        = dz_r;
endmodule

// File: tb/tb_seq_div_16by8.sv
// Directed bench for seq_div_16by8: fixed vectors, round trips, back-pressure, reset.
module tb_seq_div_16by8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_err = 0;
  int   n_chk = 0;

  seq_div_16by8_if #(.N(8)) bus ();
  seq_div_16by8 #(.N(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

`ifdef DIV_ZERO_SHORTCUT_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 16;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one operation, scrambles the operands right after acceptance,
  // holds the result for 'hold' cycles, then drains it.
  task automatic op(input string tag, input logic [15:0] dd, input logic [7:0] dv,
                    input logic [15:0] eq, input logic [7:0] er, input logic edz,
                    input int elat, input int hold);
    int lat;
    @(negedge clk);
    chk({tag, ".in_ready_before"}, {31'd0, bus.in_ready}, 32'd1);
    bus.dividend = dd;
    bus.divisor  = dv;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.dividend = ~dd;
    bus.divisor  = dv ^ 8'h5A;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, lat, elat);
    chk({tag, ".quotient"}, {16'd0, bus.quotient}, {16'd0, eq});
    chk({tag, ".remainder"}, {24'd0, bus.remainder}, {24'd0, er});
    chk({tag, ".dz"}, {31'd0, bus.dz}, {31'd0, edz});
    chk({tag, ".in_ready_done"}, {31'd0, bus.in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({tag, ".hold_q"}, {16'd0, bus.quotient}, {16'd0, eq});
      chk({tag, ".hold_r"}, {24'd0, bus.remainder}, {24'd0, er});
      chk({tag, ".hold_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, ".drain_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, ".drain_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    logic [7:0]  a, b;
    logic [15:0] dd;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;

    // Reset values, and out_ready while idle must do nothing.
    #12;
    chk("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst.quotient", {16'd0, bus.quotient}, 32'd0);
    chk("rst.remainder", {24'd0, bus.remainder}, 32'd0);
    chk("rst.dz", {31'd0, bus.dz}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("idle_oready.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("idle_oready.in_ready", {31'd0, bus.in_ready}, 32'd1);

    op("basic",   16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 16, 0);
    op("k1000_7", 16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0, 16, 0);
    op("div1",    16'h1234, 8'h01, 16'h1234, 8'h00, 1'b0, 16, 0);
    op("divzero", 16'hABCD, 8'h00, 16'hFFFF, 8'hCD, 1'b1, DZ_LAT, 0);
    op("dz_clear",16'h0010, 8'h04, 16'h0004, 8'h00, 1'b0, 16, 0);
    op("bp",      16'h00FF, 8'h10, 16'h000F, 8'h0F, 1'b0, 16, 5);
    op("small",   16'h0005, 8'hFF, 16'h0000, 8'h05, 1'b0, 16, 0);
    op("zero",    16'h0000, 8'h01, 16'h0000, 8'h00, 1'b0, 16, 0);

    // Multiplier round trips: corner operands then random ones.
    op("rt_ff_ff", 16'd255 * 16'd255, 8'hFF, 16'h00FF, 8'h00, 1'b0, 16, 0);
    op("rt_ff_01", 16'h00FF,          8'h01, 16'h00FF, 8'h00, 1'b0, 16, 0);
    op("rt_01_ff", 16'h00FF,          8'hFF, 16'h0001, 8'h00, 1'b0, 16, 0);
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      dd = 16'(a) * 16'(b);
      op("rt_rand", dd, b, {8'h00, a}, 8'h00, 1'b0, 16, 0);
    end

    // Reset at iteration 7, then a fresh operation.
    @(negedge clk);
    bus.dividend = 16'h1234;
    bus.divisor  = 8'h03;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("midrst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst.quotient", {16'd0, bus.quotient}, 32'd0);
    chk("midrst.remainder", {24'd0, bus.remainder}, 32'd0);
    chk("midrst.dz", {31'd0, bus.dz}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    op("post_rst", 16'h0064, 8'h0A, 16'h000A, 8'h00, 1'b0, 16, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
